// File: rtl/sat_up_period_cntr_if.sv
// Measurement-side bundle for sat_up_period_cntr: enable/event in,
// captured interval, valid pulse and saturation flag out.
interface sat_up_period_cntr_if #(
    parameter int NUM_CNTR_BITS = 5
) ();
    logic                     enable;
    logic                     eventIn;
    logic [NUM_CNTR_BITS-1:0] count;
    logic                     countValid;
    logic                     saturated;

    modport master (
        output enable,
        output eventIn,
        input  count,
        input  countValid,
        input  saturated
    );

    modport slave (
        input  enable,
        input  eventIn,
        output count,
        output countValid,
        output saturated
    );
endinterface

// File: rtl/sat_up_period_cntr.sv
// Saturating up-counter measuring clock cycles between rising edges
// of an asynchronous event input; captures the interval on each edge.
module sat_up_period_cntr #(
    parameter int NUM_CNTR_BITS = 5,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    sat_up_period_cntr_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        MEASURING = 2'd2
    } state_t;

    localparam logic [NUM_CNTR_BITS-1:0] MAX_CNT = '1;
    localparam logic [NUM_CNTR_BITS-1:0] ONE_CNT = NUM_CNTR_BITS'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_ev_prev;
    logic [NUM_CNTR_BITS-1:0] r_cntr;
    logic [NUM_CNTR_BITS-1:0] w_cntr_nxt;
    logic                     r_ovf;
    logic                     w_ovf_nxt;
    logic                     w_cap;
    logic                     w_ev_sync;
    logic                     w_rise;
    logic [NUM_CNTR_BITS-1:0] r_count;
    logic                     r_count_valid;
    logic                     r_saturated;

    assign w_ev_sync = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_ev_sync & ~r_ev_prev;

    // Synchroniser chain and edge-history flop; runs in every state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync    <= '0;
            r_ev_prev <= 1'b0;
        end else begin
            r_sync[0] <= bus.eventIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_ev_prev <= w_ev_sync;
        end
    end

    // State, interval counter and overflow registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cntr  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cntr  <= w_cntr_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Next state and counter; enable low overrides a coincident rise.
    always_comb begin
        w_state_nxt = r_state;
        w_cntr_nxt  = r_cntr;
        w_ovf_nxt   = r_ovf;
        w_cap       = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = IDLE;
            w_cntr_nxt  = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt = ARMED;
                    w_cntr_nxt  = '0;
                    w_ovf_nxt   = 1'b0;
                end
                ARMED: begin
                    if (w_rise) begin
                        w_state_nxt = MEASURING;
                        w_cntr_nxt  = ONE_CNT;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                MEASURING: begin
                    if (w_rise) begin
                        w_cap      = 1'b1;
                        w_cntr_nxt = ONE_CNT;
                        w_ovf_nxt  = 1'b0;
                    end else if (r_cntr != MAX_CNT) begin
                        w_cntr_nxt = r_cntr + ONE_CNT;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cntr_nxt  = '0;
                    w_ovf_nxt   = 1'b0;
                end
            endcase
        end
    end

    // Output capture; count and saturated hold between captures.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_saturated   <= 1'b0;
        end else begin
            r_count_valid <= w_cap;
            if (w_cap) begin
                r_count     <= r_cntr;
                r_saturated <= r_ovf;
            end
        end
    end

    assign bus.count      = r_count;
    assign bus.countValid = r_count_valid;
    assign bus.saturated  = r_saturated;
endmodule

// File: doc/sat_up_period_cntr.md
Name: sat_up_period_cntr

Overview:
Saturating up-counter that measures the number of clock cycles between consecutive rising edges of an event input. It is the measuring counterpart of the loadable saturating down-counter: where that block turns a loaded count into a timed `zeroed` event, this block turns timed events back into a count. It sits in the PLL loop as the period/interval measurement front end. Its output can be fed to a divider-setting down-counter or to loop-control logic.

Parameters:
NUM_CNTR_BITS, 5, width of the counter and of `count`; the saturation value is 2^NUM_CNTR_BITS-1.
SYNC_STAGES, 2, number of synchroniser flops on `eventIn`; legal range is 1..3.

Ports:
clock  input  1  single system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
enable  input  1  measurement enable; low forces IDLE.
eventIn  input  1  event signal, asynchronous to `clock`; only rising edges are significant.
count  output  NUM_CNTR_BITS  last captured interval in clock cycles, registered.
countValid  output  1  one-cycle pulse when `count` and `saturated` update.
saturated  output  1  captured interval exceeded the saturation value; updates with `count`.

Behaviour:
- Reset:
  - Synchronous and active-high; it has priority over everything else.
  - Next edge: all synchroniser flops = 0, edge-history flop = 0, internal counter `cntr` = 0, overflow bit `ovf` = 0.
  - Outputs: `count` = 0, `countValid` = 0, `saturated` = 0.
  - State = IDLE.
- Synchroniser and edge detect:
  - `eventIn` passes through SYNC_STAGES flops to give `evSync`.
  - `rise` = `evSync` & !`evPrev`, where `evPrev` is `evSync` delayed by one flop.
  - Edge detection runs in every state, including IDLE, so a level already high at enable does not produce a false rise.
- FSM states: IDLE, ARMED, MEASURING.
  - IDLE: `cntr` = 0, `ovf` = 0. Goes to ARMED on the next edge when `enable` = 1.
  - ARMED: waits for the first `rise`. On `rise`: `cntr` <= 1, `ovf` <= 0, go to MEASURING. No capture and no `countValid` on this first edge.
  - MEASURING, no `rise`:
    - If `cntr` < max: `cntr` <= `cntr` + 1.
    - Else (`cntr` = max): `cntr` holds and `ovf` <= 1.
  - MEASURING, `rise`:
    - `count` <= `cntr`, `saturated` <= `ovf`, `countValid` <= 1.
    - Then `cntr` <= 1, `ovf` <= 0, stay in MEASURING.
  - Any state with `enable` = 0: go to IDLE, clear `cntr` and `ovf`. `count` and `saturated` hold their last values; `countValid` = 0.
- Interval definition: if rises are detected in cycles t0 and t1, the captured `count` = t1 - t0.
  - Minimum measurable interval is 2.
  - Intervals 2..max are captured exactly with `saturated` = 0.
  - An interval of exactly max gives `count` = max, `saturated` = 0.
  - Any interval > max gives `count` = max, `saturated` = 1.
- Latency: `count` and `countValid` appear SYNC_STAGES+1 clock edges after `eventIn` is first sampled high.
- `countValid` is high for exactly 1 cycle per capture and is never high in IDLE or ARMED.
- Simultaneous events:
  - `enable` falling in the same cycle as `rise`: `enable` wins, so no capture and the block goes to IDLE.
  - `reset` together with anything: `reset` wins.
- Re-enable: after IDLE, the first `rise` only arms again; a fresh full interval is needed before the next capture.
- Counter arithmetic is unsigned NUM_CNTR_BITS wide and never wraps.

Test Plan (NUM_CNTR_BITS=5, SYNC_STAGES=2):
1. Reset, set `enable`=1, then give an `eventIn` rise every 10 cycles -> no pulse on the first rise; each later rise gives a `countValid` pulse with `count`=10, `saturated`=0, arriving 3 cycles after the raw rise.
2. Give intervals of 31, 32 and 40 -> `count`=31 with `saturated`=0, then `count`=31 with `saturated`=1, then `count`=31 with `saturated`=1.
3. Toggle `eventIn` every cycle (high 1, low 1) -> `count`=2 on every capture; then hold high 5 and low 7 -> `count`=12 (only rising edges count).
4. With `count`=10 captured, drop `enable` mid-interval for 4 cycles, then re-enable -> `count` holds 10 and no pulse; the first rise after re-enable gives no pulse; the next interval of 8 gives `count`=8.
5. Drop `enable` in the same cycle that a synchronised rise is detected -> no `countValid` pulse and the block enters IDLE.
6. Assert `reset` mid-interval with `count`=10 -> on the next edge `count`=0, `saturated`=0, `countValid`=0 and state is IDLE; with `eventIn` held high, release `reset` with `enable`=1 -> no capture until two later rises.
